sdram_bram_responder: RTL and testbench



---
 rtl/sdram_bram_pkg.sv | 14 +
 rtl/sdram_bram_array.sv | 30 +++
 rtl/sdram_bram_responder.sv | 170 +++++++++++++++++
 tb/tb_sdram_bram_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bram_pkg.sv
// Shared state encoding and constants for the block-RAM backed sdram_* responder.
package sdram_bram_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAITST,
    ST_ACK
  } state_e;

  localparam int          WAIT_CNT_W      = 3;
  localparam logic [15:0] CLR_VAL_DEFAULT = 16'o000000;

endpackage

// File: rtl/sdram_bram_array.sv
// Single-port 2^AW x 16 RAM with per-byte write enables and an enabled, registered read port.
module sdram_bram_array #(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   wdata_i,
  input  logic          re_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
  end

  // Output register only loads on a completed read, so it doubles as the held read-data latch.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller on the kernel's sdram_* bus.
// Define SDRAM_BRAM_MEM_CLEAR_EN to sweep CLR_VAL through the whole RAM after every reset.
module sdram_bram_responder
  import sdram_bram_pkg::*;
#(
  parameter int          AW      = 14,
  parameter int          WAIT    = 1,
  parameter logic [15:0] CLR_VAL = CLR_VAL_DEFAULT
) (
  input  logic        clk_p,
  input  logic        sdram_reset,
  input  logic        sdram_stb,
  input  logic        sdram_we,
  input  logic [1:0]  sdram_sel,
  input  logic [21:1] sdram_adr,
  input  logic [15:0] sdram_out,
  output logic [15:0] sdram_dat,
  output logic        sdram_ack,
  output logic        sdram_ready,
  output logic        mem_led
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT - 1);

`ifdef SDRAM_BRAM_MEM_CLEAR_EN
  localparam state_e RESET_STATE = ST_INIT;
  logic [AW-1:0] clrAdr_q;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready_q;
  logic                  capWe_q;
  logic [1:0]            capSel_q;
  logic [AW-1:0]         capAdr_q;
  logic [15:0]           capDat_q;

  logic                  capture;
  logic                  waitDone;
  logic [AW-1:0]         ramAddr;
  logic [1:0]            ramWe;
  logic [15:0]           ramWdata;
  logic                  ramRe;
  logic                  unusedAdr;

  assign unusedAdr = ^sdram_adr[21:AW+1];
  assign capture   = (state_q == ST_IDLE) && ready_q && sdram_stb;
  assign waitDone  = (state_q == ST_WAITST) && (cnt_q == '0) && sdram_stb;

  always_ff @(posedge clk_p) begin
    if (sdram_reset) state_q <= RESET_STATE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
`ifdef SDRAM_BRAM_MEM_CLEAR_EN
        if (clrAdr_q == '1) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (capture) begin
          if (WAIT == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAITST;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAITST: begin
        if (!sdram_stb)        state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_ACK;
        else                   cnt_d   = cnt_q - WAIT_CNT_W'(1);
      end
      ST_ACK: begin
        if (!sdram_stb) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM is driven one cycle ahead of ACK entry so its registered read lands exactly at that edge;
  // with WAIT=0 that cycle is the capture cycle itself, hence the raw bus in IDLE.
  always_comb begin
    sdram_ack = (state_q == ST_ACK) && sdram_stb;
    mem_led   = !((state_q == ST_WAITST) || (state_q == ST_ACK));
    ramAddr   = capAdr_q;
    ramWdata  = capDat_q;
    ramWe     = 2'b00;
    ramRe     = 1'b0;
    case (state_q)
      ST_INIT: begin
`ifdef SDRAM_BRAM_MEM_CLEAR_EN
        ramAddr = clrAdr_q;
        ramWe   = 2'b11;
`endif
        ramWdata = CLR_VAL;
      end
      ST_IDLE: begin
        ramAddr  = sdram_adr[AW:1];
        ramWdata = sdram_out;
        if (capture && (WAIT == 0)) begin
          if (sdram_we) ramWe = sdram_sel;
          else          ramRe = 1'b1;
        end
      end
      ST_WAITST: begin
        if (waitDone) begin
          if (capWe_q) ramWe = capSel_q;
          else         ramRe = 1'b1;
        end
      end
      default: ;
    endcase
    if (sdram_reset) begin
      ramWe = 2'b00;
      ramRe = 1'b0;
    end
  end

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      capWe_q  <= 1'b0;
      capSel_q <= 2'b00;
      capAdr_q <= '0;
      capDat_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= (state_q != ST_INIT);
      if (capture) begin
        capWe_q  <= sdram_we;
        capSel_q <= sdram_sel;
        capAdr_q <= sdram_adr[AW:1];
        capDat_q <= sdram_out;
      end
    end
  end

`ifdef SDRAM_BRAM_MEM_CLEAR_EN
  always_ff @(posedge clk_p) begin
    if (sdram_reset)              clrAdr_q <= '0;
    else if (state_q == ST_INIT)  clrAdr_q <= clrAdr_q + AW'(1);
  end
`endif

  assign sdram_ready = ready_q;

  sdram_bram_array #(
    .AW(AW)
  ) u_array (
    .clk_i   (clk_p),
    .rst_i   (sdram_reset),
    .addr_i  (ramAddr),
    .we_i    (ramWe),
    .wdata_i (ramWdata),
    .re_i    (ramRe),
    .rdata_o (sdram_dat)
  );

endmodule

// File: tb/tb_sdram_bram_responder.sv
// Directed bench for sdram_bram_responder with a transaction-level memory model checked every cycle.
`timescale 1ns/1ps
module tb_sdram_bram_responder;

`ifdef SDRAM_BRAM_MEM_CLEAR_EN
  localparam int          AW        = 4;
  localparam logic [21:1] ADR1      = 21'o000101;
  localparam logic [21:1] ADR2      = 21'o000102;
  localparam logic [21:1] ADR3      = 21'o000103;
  localparam logic [21:1] ALIAS_ADR = 21'h000015;
  localparam int          READY_LAT = 17;
`else
  localparam int          AW        = 14;
  localparam logic [21:1] ADR1      = 21'o000100;
  localparam logic [21:1] ADR2      = 21'o000200;
  localparam logic [21:1] ADR3      = 21'o000300;
  localparam logic [21:1] ALIAS_ADR = 21'h004005;
  localparam int          READY_LAT = 1;
`endif
  localparam int          WAIT  = 1;
  localparam int          DEPTH = 2**AW;
  localparam logic [15:0] CLR   = 16'o000000;

  logic        clk_p = 1'b0;
  logic        sdram_reset;
  logic        sdram_stb;
  logic        sdram_we;
  logic [1:0]  sdram_sel;
  logic [21:1] sdram_adr;
  logic [15:0] sdram_out;
  logic [15:0] sdram_dat;
  logic        sdram_ack;
  logic        sdram_ready;
  logic        mem_led;

  int compared   = 0;
  int mismatched = 0;

  sdram_bram_responder #(
    .AW      (AW),
    .WAIT    (WAIT),
    .CLR_VAL (CLR)
  ) dut (
    .clk_p       (clk_p),
    .sdram_reset (sdram_reset),
    .sdram_stb   (sdram_stb),
    .sdram_we    (sdram_we),
    .sdram_sel   (sdram_sel),
    .sdram_adr   (sdram_adr),
    .sdram_out   (sdram_out),
    .sdram_dat   (sdram_dat),
    .sdram_ack   (sdram_ack),
    .sdram_ready (sdram_ready),
    .mem_led     (mem_led)
  );

  always #5 clk_p = ~clk_p;

  // Transaction-level reference: memory image, last read word, and where the current request stands.
  logic [15:0] modelMem [DEPTH];
  logic [15:0] expDat;
  logic        expReady;
  logic        wasReady;
  bit          reqActive;
  bit          ackOpen;
  int          edgesInReq;
  int          edgesSinceRelease;
  bit          curWe;
  logic [1:0]  curSel;
  int          curIdx;
  logic [15:0] curData;
  int          modelWrites = 0;
  int          dutWrites   = 0;
  bit          checkEn     = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0o, required %0o at %0t", name, act, exp, $time);
    end
  endtask

  task automatic performModel();
    if (curWe) begin
      if (curSel[0]) modelMem[curIdx][7:0]  = curData[7:0];
      if (curSel[1]) modelMem[curIdx][15:8] = curData[15:8];
      if (curSel != 2'b00) modelWrites++;
    end else begin
      expDat = modelMem[curIdx];
    end
  endtask

  always @(posedge clk_p) begin
    if (sdram_reset) begin
      reqActive         = 1'b0;
      ackOpen           = 1'b0;
      expDat            = 16'h0000;
      expReady          = 1'b0;
      edgesSinceRelease = 0;
    end else begin
      wasReady = expReady;
      edgesSinceRelease++;
`ifdef SDRAM_BRAM_MEM_CLEAR_EN
      if (edgesSinceRelease <= DEPTH) modelMem[edgesSinceRelease-1] = CLR;
      expReady = (edgesSinceRelease >= DEPTH + 1);
`else
      expReady = 1'b1;
`endif
      if (ackOpen) begin
        if (!sdram_stb) ackOpen = 1'b0;
      end else if (reqActive) begin
        edgesInReq++;
        if (!sdram_stb) begin
          reqActive = 1'b0;
        end else if (edgesInReq == WAIT) begin
          performModel();
          reqActive = 1'b0;
          ackOpen   = 1'b1;
        end
      end else if (wasReady && sdram_stb) begin
        curWe   = sdram_we;
        curSel  = sdram_sel;
        curIdx  = int'(sdram_adr) & (DEPTH - 1);
        curData = sdram_out;
        if (WAIT == 0) begin
          performModel();
          ackOpen = 1'b1;
        end else begin
          reqActive  = 1'b1;
          edgesInReq = 0;
        end
      end
    end
  end

  always @(negedge clk_p) begin
    if (checkEn) begin
      checkOutput("ack",   16'(sdram_ack),   16'(ackOpen && sdram_stb));
      checkOutput("dat",   sdram_dat,        expDat);
      checkOutput("ready", 16'(sdram_ready), 16'(expReady));
      checkOutput("led",   16'(mem_led),     16'(!(reqActive || ackOpen)));
    end
  end

  // Writes the DUT actually commits on the bus side (the init sweep runs with ready low).
  always @(negedge clk_p) begin
    if (!sdram_reset && sdram_ready && (dut.ramWe != 2'b00)) dutWrites++;
  end

  task automatic applyStimulus(input bit we, input logic [1:0] sel, input logic [21:1] adr,
                               input logic [15:0] data, input int hold,
                               output int latency, output logic [15:0] rdata, output int ackHigh);
    bit got;
    @(posedge clk_p); #2;
    sdram_stb = 1'b1;
    sdram_we  = we;
    sdram_sel = sel;
    sdram_adr = adr;
    sdram_out = data;
    latency   = 0;
    ackHigh   = 0;
    got       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_p);
      latency++;
      @(negedge clk_p);
      if (sdram_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ack_timeout: actual no ack, required ack within 20 cycles at %0t", $time);
    end
    rdata = sdram_dat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_p);
      @(negedge clk_p);
      if (sdram_ack) ackHigh++;
    end
    @(posedge clk_p); #2;
    sdram_stb = 1'b0;
    sdram_we  = 1'b0;
  endtask

  task automatic waitReady(output int zeroCycles);
    zeroCycles = 0;
    for (int i = 0; i < 2*DEPTH + 100; i++) begin
      @(negedge clk_p);
      if (sdram_ready) return;
      zeroCycles++;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL ready_timeout: actual ready low, required ready high at %0t", $time);
  endtask

  task automatic pulseReset();
    @(posedge clk_p); #2;
    sdram_reset = 1'b1;
    @(posedge clk_p); #2;
    sdram_reset = 1'b0;
  endtask

  int          lat;
  int          hi;
  int          zeros;
  int          writesBefore;
  logic [15:0] rd;
  bit          sawAck;

  initial begin
    sdram_reset = 1'b1;
    sdram_stb   = 1'b0;
    sdram_we    = 1'b0;
    sdram_sel   = 2'b00;
    sdram_adr   = '0;
    sdram_out   = 16'h0000;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 16'h0000;
    repeat (3) @(posedge clk_p);
    #2 checkEn = 1'b1;
    @(negedge clk_p);
    checkOutput("reset_ack",   16'(sdram_ack),   16'd0);
    checkOutput("reset_ready", 16'(sdram_ready), 16'd0);
    checkOutput("reset_dat",   sdram_dat,        16'd0);
    checkOutput("reset_led",   16'(mem_led),     16'd1);
    @(posedge clk_p); #2 sdram_reset = 1'b0;
    waitReady(zeros);
    checkOutput("ready_latency", 16'(zeros), 16'(READY_LAT));

    $display("[TB] word write and read back");
    applyStimulus(1'b1, 2'b11, ADR1, 16'o123456, 0, lat, rd, hi);
    checkOutput("write_latency", 16'(lat), 16'd2);
    applyStimulus(1'b0, 2'b00, ADR1, 16'h0000, 0, lat, rd, hi);
    checkOutput("read_latency", 16'(lat), 16'd2);
    checkOutput("read_word", rd, 16'o123456);

    $display("[TB] byte lane writes");
    applyStimulus(1'b1, 2'b11, ADR2, 16'o177777, 0, lat, rd, hi);
    applyStimulus(1'b1, 2'b01, ADR2, 16'o000000, 0, lat, rd, hi);
    applyStimulus(1'b0, 2'b00, ADR2, 16'h0000, 0, lat, rd, hi);
    checkOutput("byte_low_cleared", rd, 16'o177400);
    applyStimulus(1'b1, 2'b10, ADR2, 16'o000000, 0, lat, rd, hi);
    applyStimulus(1'b0, 2'b00, ADR2, 16'h0000, 0, lat, rd, hi);
    checkOutput("byte_high_cleared", rd, 16'o000000);
    applyStimulus(1'b1, 2'b00, ADR2, 16'o111111, 0, lat, rd, hi);
    applyStimulus(1'b0, 2'b00, ADR2, 16'h0000, 0, lat, rd, hi);
    checkOutput("sel00_no_change", rd, 16'o000000);

    $display("[TB] address aliasing");
    applyStimulus(1'b1, 2'b11, ALIAS_ADR, 16'o000777, 0, lat, rd, hi);
    applyStimulus(1'b0, 2'b00, 21'h000005, 16'h0000, 0, lat, rd, hi);
    checkOutput("alias_read", rd, 16'o000777);

    $display("[TB] aborted write");
    @(posedge clk_p); #2;
    sdram_stb = 1'b1;
    sdram_we  = 1'b1;
    sdram_sel = 2'b11;
    sdram_adr = ADR1;
    sdram_out = 16'o000001;
    @(posedge clk_p); #2;
    sdram_stb = 1'b0;
    sdram_we  = 1'b0;
    sawAck    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_p);
      if (sdram_ack) sawAck = 1'b1;
    end
    checkOutput("abort_no_ack", 16'(sawAck), 16'd0);
    checkOutput("abort_dat_held", sdram_dat, 16'o000777);
    applyStimulus(1'b0, 2'b00, ADR1, 16'h0000, 0, lat, rd, hi);
    checkOutput("abort_old_value", rd, 16'o123456);

    $display("[TB] held strobe");
    writesBefore = dutWrites;
    applyStimulus(1'b1, 2'b11, ADR3, 16'o070707, 5, lat, rd, hi);
    checkOutput("held_ack_cycles", 16'(hi), 16'd5);
    @(negedge clk_p);
    checkOutput("held_ack_dropped", 16'(sdram_ack), 16'd0);
    checkOutput("held_single_write", 16'(dutWrites - writesBefore), 16'd1);
    applyStimulus(1'b0, 2'b00, ADR3, 16'h0000, 0, lat, rd, hi);
    checkOutput("held_read", rd, 16'o070707);

`ifndef SDRAM_BRAM_MEM_CLEAR_EN
    $display("[TB] reset during wait state");
    @(posedge clk_p); #2;
    sdram_stb = 1'b1;
    sdram_we  = 1'b1;
    sdram_sel = 2'b11;
    sdram_adr = ADR1;
    sdram_out = 16'o000002;
    @(posedge clk_p); #2;
    sdram_reset = 1'b1;
    @(posedge clk_p); #2;
    sdram_reset = 1'b0;
    sdram_stb   = 1'b0;
    sdram_we    = 1'b0;
    waitReady(zeros);
    checkOutput("rst_mid_ready", 16'(zeros), 16'd1);
    applyStimulus(1'b0, 2'b00, ADR1, 16'h0000, 0, lat, rd, hi);
    checkOutput("rst_mid_no_write", rd, 16'o123456);
`else
    $display("[TB] init sweep after reset");
    pulseReset();
    zeros  = 0;
    sawAck = 1'b0;
    for (int i = 0; i < 2*DEPTH + 10; i++) begin
      @(negedge clk_p);
      if (sdram_ready) break;
      zeros++;
      if (sdram_ack) sawAck = 1'b1;
      @(posedge clk_p); #2;
      sdram_stb = (i >= 2) && (i < 10);
      sdram_we  = 1'b0;
      sdram_adr = ADR1;
    end
    sdram_stb = 1'b0;
    checkOutput("sweep_ready_latency", 16'(zeros), 16'd17);
    checkOutput("sweep_no_ack", 16'(sawAck), 16'd0);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 2'b00, 21'(a), 16'h0000, 0, lat, rd, hi);
      checkOutput("sweep_cleared", rd, 16'o000000);
    end
    applyStimulus(1'b1, 2'b11, 21'd9, 16'o052525, 0, lat, rd, hi);
    pulseReset();
    repeat (5) @(negedge clk_p);
    pulseReset();
    waitReady(zeros);
    checkOutput("sweep_restart_latency", 16'(zeros), 16'd17);
    applyStimulus(1'b0, 2'b00, 21'd9, 16'h0000, 0, lat, rd, hi);
    checkOutput("sweep_restart_cleared", rd, 16'o000000);
`endif

    repeat (3) @(posedge clk_p);
    checkOutput("total_writes", 16'(dutWrites), 16'(modelWrites));
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
